// File: rtl/core_ldst_bus.sv
// Load/store bus adapter: turns one-shot mem_start requests into Avalon-MM
// read/write commands, with a per-state watchdog that aborts stuck transfers.
module core_ldst_bus #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_start,
  input  logic        mem_write,
  input  logic        mem_user,
  input  logic [29:0] mem_addr,
  input  logic [3:0]  mem_data_be,
  input  logic [31:0] mem_data_wr,
  output logic        mem_ready,
  output logic [31:0] mem_data_rd,
  output logic        mem_fault,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [3:0]  avl_byteenable,
  output logic [31:0] avl_writedata,
  output logic        avl_user,
  input  logic        avl_waitrequest,
  input  logic        avl_readdatavalid,
  input  logic [31:0] avl_readdata,
  input  logic [1:0]  avl_response
);

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] wdog;
  logic [7:0] wdog_inc;
  logic       timeout_hit;

  // Abort fires on the cycle whose count would bring the watchdog to TIMEOUT,
  // so the command stays asserted for exactly TIMEOUT cycles.
  assign wdog_inc    = wdog + 8'd1;
  assign timeout_hit = (wdog_inc == TIMEOUT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wdog           <= 8'd0;
      mem_ready      <= 1'b0;
      mem_fault      <= 1'b0;
      mem_data_rd    <= 32'd0;
      avl_address    <= 32'd0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      avl_byteenable <= 4'd0;
      avl_writedata  <= 32'd0;
      avl_user       <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_start) begin
            avl_address    <= {mem_addr, 2'b00};
            avl_byteenable <= mem_data_be;
            avl_writedata  <= mem_data_wr;
            avl_user       <= mem_user;
            avl_read       <= !mem_write;
            avl_write      <= mem_write;
            wdog           <= 8'd0;
            state          <= CMD;
          end
        end
        CMD: begin
          // An accepted command wins over a timeout landing in the same cycle.
          if (!avl_waitrequest) begin
            avl_read  <= 1'b0;
            avl_write <= 1'b0;
            wdog      <= 8'd0;
            if (avl_write) begin
              mem_ready <= 1'b1;
              mem_fault <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= RDWAIT;
            end
          end else if (timeout_hit) begin
            avl_read  <= 1'b0;
            avl_write <= 1'b0;
            wdog      <= 8'd0;
            mem_ready <= 1'b1;
            mem_fault <= 1'b1;
            state     <= IDLE;
          end else begin
            wdog <= wdog_inc;
          end
        end
        RDWAIT: begin
          if (avl_readdatavalid) begin
            mem_data_rd <= avl_readdata;
            mem_fault   <= (avl_response != 2'b00);
            mem_ready   <= 1'b1;
            wdog        <= 8'd0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            mem_fault <= 1'b1;
            mem_ready <= 1'b1;
            wdog      <= 8'd0;
            state     <= IDLE;
          end else begin
            wdog <= wdog_inc;
          end
        end
        default: begin
          avl_read  <= 1'b0;
          avl_write <= 1'b0;
          wdog      <= 8'd0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/core_ldst_bus.md
CORE_LDST_BUS -- requirements
Module: core_ldst_bus

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in any one non-idle state before abort, range 1..255.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 mem_start  in  1  one-cycle pulse from load/store control requesting one transfer.
REQ-005 mem_write  in  1  1 = store, 0 = load; sampled with mem_start.
REQ-006 mem_user  in  1  unprivileged access; sampled with mem_start.
REQ-007 mem_addr  in  30  word address; sampled with mem_start.
REQ-008 mem_data_be  in  4  byte enables; sampled with mem_start.
REQ-009 mem_data_wr  in  32  store data; sampled with mem_start.
REQ-010 mem_ready  out  1  one-cycle completion pulse for the current transfer.
REQ-011 mem_data_rd  out  32  load data; valid in the mem_ready cycle and held until the next load completes.
REQ-012 mem_fault  out  1  fault status of the transfer; valid with mem_ready.
REQ-013 avl_address  out  32  byte address = {mem_addr, 2'b00}.
REQ-014 avl_read, avl_write  out  1 each  bus commands; never both 1.
REQ-015 avl_byteenable  out  4; avl_writedata  out  32; avl_user  out  1  registered copies of the request.
REQ-016 avl_waitrequest  in  1  slave stall; a command is accepted in a cycle where it is asserted and avl_waitrequest=0.
REQ-017 avl_readdatavalid  in  1; avl_readdata  in  32; avl_response  in  2  read return (pipelined, latency >= 1); 2'b00 = OKAY.

Function
REQ-018 States: IDLE, CMD, RDWAIT.
REQ-019 IDLE + mem_start: latch all request fields -> CMD, driving avl_read=!mem_write or avl_write=mem_write from the next cycle (one-cycle launch latency).
REQ-020 mem_start outside IDLE is ignored; request registers are not modified.
REQ-021 CMD: hold address, data, enables and command stable while avl_waitrequest=1.
REQ-022 CMD write accepted -> IDLE, mem_ready=1 next cycle, mem_fault=0.
REQ-023 CMD read accepted -> RDWAIT with command deasserted next cycle.
REQ-024 RDWAIT + avl_readdatavalid: mem_data_rd <= avl_readdata; mem_fault <= (avl_response != 0); mem_ready=1 next cycle; -> IDLE.
REQ-025 avl_readdatavalid in IDLE or CMD is ignored.
REQ-026 An 8-bit watchdog clears on every state change and increments each cycle in CMD or RDWAIT.
REQ-027 Watchdog reaching TIMEOUT: deassert command, -> IDLE, mem_ready=1 with mem_fault=1 next cycle; mem_data_rd unchanged.
REQ-028 Minimum turnaround: a write with waitrequest=0 completes 2 cycles after mem_start; a read with latency L completes 2+L cycles after mem_start.
REQ-029 mem_ready and mem_start in the same cycle: a new transfer is accepted only if the state is already IDLE in that cycle.
REQ-030 Exactly one mem_ready pulse per accepted mem_start.

Reset
REQ-031 rst_n low at any time, including mid-transfer: state IDLE, watchdog 0, avl_read=avl_write=0, mem_ready=0, mem_fault=0, mem_data_rd=0, avl_address=0, avl_byteenable=0, avl_writedata=0, avl_user=0.
REQ-032 A transfer in flight at reset is abandoned without a mem_ready pulse; a late avl_readdatavalid after reset is ignored.

Verification
REQ-033 Store: mem_addr=30'h0000_0040, be=4'b0011, data=32'hDEAD_BEEF, waitrequest=0 -> avl_write for 1 cycle at address 32'h0000_0100, mem_ready at cycle +2, fault=0.
REQ-034 Load with waitrequest=1 for 3 cycles, readdata=32'h1234_5678 at latency 2 -> command held stable for 4 cycles, mem_data_rd=32'h1234_5678, fault=0.
REQ-035 Load with avl_response=2'b10 -> mem_ready with mem_fault=1 and the returned data captured.
REQ-036 TIMEOUT=4, waitrequest stuck at 1 -> command drops after 4 cycles in CMD, mem_ready=1 with mem_fault=1.
REQ-037 mem_start pulsed again while in RDWAIT -> ignored; exactly one mem_ready; avl_address unchanged.
REQ-038 rst_n asserted in RDWAIT, then readdatavalid arrives -> no mem_ready, all outputs at reset values.
